// File: rtl/i2c_slave_regs_if.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_regs_if
//  Brief    : Register-side signals of the I2C register slave (write strobe,
//             busy flag, register 0 debug view).
//  Revision : 1.0 - initial release
// ============================================================================
interface i2c_slave_regs_if;
   logic       wr_strobe;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic [7:0] reg0_data;

   modport slave  (output wr_strobe, wr_addr, wr_data, busy, reg0_data);
   modport master (input  wr_strobe, wr_addr, wr_data, busy, reg0_data);
endinterface
`default_nettype wire

// File: rtl/i2c_slave_regs.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_regs
//  Brief    : I2C slave exposing 16 x 8-bit registers with auto-incrementing
//             pointer; SCL/SDA are synchronised and glitch-filtered.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_regs #(
   parameter logic [6:0] DEV_ADDR   = 7'h50,
   parameter int         FILTER_LEN = 3
) (
   input  wire             sys_clk,
   input  wire             rst,
   input  wire             scl,
   inout  wire             sda,
   i2c_slave_regs_if.slave regs_bus
);
   localparam int c_CNT_W = $clog2(FILTER_LEN + 1);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      DEV       = 4'd1,
      ACK_DEV   = 4'd2,
      WADDR     = 4'd3,
      ACK_WADDR = 4'd4,
      WDATA     = 4'd5,
      ACK_WDATA = 4'd6,
      RDATA     = 4'd7,
      RACK      = 4'd8,
      IGNORE    = 4'd9
   } state_t;

   logic [1:0] w_line_raw;
   logic [1:0] w_line_flt;
   assign w_line_raw = {sda, scl};

   // Index 0 = SCL, index 1 = SDA; a new level needs FILTER_LEN equal samples
   generate
      for (genvar i = 0; i < 2; i++) begin : g_filter
         logic [1:0]         r_sync;
         logic [c_CNT_W-1:0] r_cnt;
         logic               r_flt;
         always_ff @(posedge sys_clk or posedge rst) begin
            if (rst) begin
               r_sync <= 2'b11;
               r_cnt  <= '0;
               r_flt  <= 1'b1;
            end else begin
               r_sync <= {r_sync[0], w_line_raw[i]};
               if (r_sync[1] == r_flt) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_CNT_W'(FILTER_LEN - 1)) begin
                  r_flt <= r_sync[1];
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + c_CNT_W'(1);
               end
            end
         end
         assign w_line_flt[i] = r_flt;
      end
   endgenerate

   logic w_scl, w_sda;
   logic r_scl_d, r_sda_d;
   logic w_scl_rise, w_scl_fall, w_start, w_stop;

   assign w_scl      = w_line_flt[0];
   assign w_sda      = w_line_flt[1];
   assign w_scl_rise =  w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl &  r_scl_d;
   assign w_start    =  w_scl &  r_scl_d &  r_sda_d & ~w_sda;
   assign w_stop     =  w_scl &  r_scl_d & ~r_sda_d &  w_sda;

   state_t     r_state;
   logic [3:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic       r_rw;
   logic       r_mack;
   logic [3:0] r_ptr;
   logic [3:0] w_ptr_next;
   logic       r_sda_low;
   logic       r_busy;
   logic       r_wr_strobe;
   logic [3:0] r_wr_addr;
   logic [7:0] r_wr_data;
   logic [7:0] r_mem [16];

   assign w_ptr_next = r_ptr + 4'd1;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_rw        <= 1'b0;
         r_mack      <= 1'b1;
         r_ptr       <= '0;
         r_sda_low   <= 1'b0;
         r_busy      <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_scl_d     <= 1'b1;
         r_sda_d     <= 1'b1;
         for (int k = 0; k < 16; k++) r_mem[k] <= '0;
      end else begin
         r_scl_d     <= w_scl;
         r_sda_d     <= w_sda;
         r_wr_strobe <= 1'b0;
         if (w_stop) begin
            r_state   <= IDLE;
            r_sda_low <= 1'b0;
            r_busy    <= 1'b0;
            r_bit_cnt <= '0;
         end else if (w_start) begin
            r_state   <= DEV;
            r_sda_low <= 1'b0;
            r_bit_cnt <= '0;
         end else begin
            case (r_state)
               DEV, WADDR, WDATA: begin
                  if (w_scl_rise) begin
                     r_shift   <= {r_shift[6:0], w_sda};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                     r_bit_cnt <= '0;
                     r_sda_low <= 1'b1;
                     case (r_state)
                        DEV: begin
                           if (r_shift[7:1] == DEV_ADDR) begin
                              r_state <= ACK_DEV;
                              r_busy  <= 1'b1;
                              r_rw    <= r_shift[0];
                           end else begin
                              r_state   <= IGNORE;
                              r_busy    <= 1'b0;
                              r_sda_low <= 1'b0;
                           end
                        end
                        WADDR: begin
                           r_ptr   <= r_shift[3:0];
                           r_state <= ACK_WADDR;
                        end
                        default: begin
                           r_mem[r_ptr] <= r_shift;
                           r_wr_strobe  <= 1'b1;
                           r_wr_addr    <= r_ptr;
                           r_wr_data    <= r_shift;
                           r_ptr        <= w_ptr_next;
                           r_state      <= ACK_WDATA;
                        end
                     endcase
                  end
               end
               ACK_DEV: begin
                  if (w_scl_fall) begin
                     if (r_rw) begin
                        r_state   <= RDATA;
                        r_shift   <= r_mem[r_ptr];
                        r_sda_low <= ~r_mem[r_ptr][7];
                     end else begin
                        r_state   <= WADDR;
                        r_sda_low <= 1'b0;
                     end
                  end
               end
               ACK_WADDR, ACK_WDATA: begin
                  if (w_scl_fall) begin
                     r_state   <= WDATA;
                     r_sda_low <= 1'b0;
                  end
               end
               RDATA: begin
                  if (w_scl_rise) begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end else if (w_scl_fall) begin
                     if (r_bit_cnt == 4'd8) begin
                        r_bit_cnt <= '0;
                        r_sda_low <= 1'b0;
                        r_state   <= RACK;
                     end else begin
                        r_shift   <= {r_shift[6:0], 1'b0};
                        r_sda_low <= ~r_shift[6];
                     end
                  end
               end
               RACK: begin
                  // Master's ACK/NACK is latched on the rise, acted on at the fall
                  if (w_scl_rise) begin
                     r_mack <= w_sda;
                  end else if (w_scl_fall) begin
                     if (!r_mack) begin
                        r_ptr     <= w_ptr_next;
                        r_state   <= RDATA;
                        r_shift   <= r_mem[w_ptr_next];
                        r_sda_low <= ~r_mem[w_ptr_next][7];
                     end else begin
                        r_state <= IGNORE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Reset also gates the drive combinationally so SDA frees without a clock
   assign sda = (r_sda_low && !rst) ? 1'b0 : 1'bz;

   assign regs_bus.wr_strobe = r_wr_strobe;
   assign regs_bus.wr_addr   = r_wr_addr;
   assign regs_bus.wr_data   = r_wr_data;
   assign regs_bus.busy      = r_busy;
   assign regs_bus.reg0_data = r_mem[0];

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_slave_regs
//  Brief    : Bit-banged I2C master with write/read scoreboards for
//             i2c_slave_regs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regs;
   localparam int Q = 15;

   logic sys_clk   = 1'b0;
   logic rst       = 1'b1;
   logic scl_m     = 1'b1;
   logic sda_m_low = 1'b0;
   wire  scl;
   wire  sda;

   int          n_run  = 0;
   int          n_fail = 0;
   logic [11:0] exp_wr_q [$];
   logic [7:0]  exp_rd_q [$];
   logic [11:0] mon_exp;
   logic [7:0]  model_mem [16];
   logic [3:0]  model_ptr;

   always #5 sys_clk = ~sys_clk;

   assign scl = scl_m;
   assign sda = sda_m_low ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_slave_regs_if regs_bus ();

   i2c_slave_regs #(
      .DEV_ADDR   (7'h50),
      .FILTER_LEN (3)
   ) dut (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .scl      (scl),
      .sda      (sda),
      .regs_bus (regs_bus)
   );

   // Every write strobe must match the oldest expected write
   always @(negedge sys_clk) begin
      if (rst === 1'b0 && regs_bus.wr_strobe === 1'b1) begin
         n_run++;
         if (exp_wr_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_wr_strobe: got addr %h data %h, expected no write",
                     regs_bus.wr_addr, regs_bus.wr_data);
         end else begin
            mon_exp = exp_wr_q.pop_front();
            if ({regs_bus.wr_addr, regs_bus.wr_data} !== mon_exp) begin
               n_fail++;
               $display("FAIL wr_scoreboard: got addr %h data %h, expected addr %h data %h",
                        regs_bus.wr_addr, regs_bus.wr_data, mon_exp[11:8], mon_exp[7:0]);
            end
         end
      end
   end

   initial begin
      #600000;
      n_fail++;
      $display("FAIL watchdog: got time limit expiry, expected run completion");
      $fatal(1, "watchdog");
   end

   task automatic wait_q();
      repeat (Q) @(negedge sys_clk);
   endtask

   task automatic bus_start();
      sda_m_low = 1'b0; wait_q();
      scl_m     = 1'b1; wait_q();
      sda_m_low = 1'b1; wait_q();
      scl_m     = 1'b0; wait_q();
   endtask

   task automatic bus_stop();
      sda_m_low = 1'b1; wait_q();
      scl_m     = 1'b1; wait_q();
      sda_m_low = 1'b0; wait_q();
   endtask

   // g: 0 clean bit, 1 one-cycle SCL high pulse while low, 2 one-cycle low pulse while high
   task automatic bus_bit(input logic b, input int g, output logic s);
      sda_m_low = ~b;
      if (g == 1) begin
         repeat (5) @(negedge sys_clk);
         scl_m = 1'b1; @(negedge sys_clk); scl_m = 1'b0;
         repeat (Q - 6) @(negedge sys_clk);
      end else wait_q();
      scl_m = 1'b1; wait_q();
      s = sda;
      if (g == 2) begin
         repeat (5) @(negedge sys_clk);
         scl_m = 1'b0; @(negedge sys_clk); scl_m = 1'b1;
         repeat (Q - 6) @(negedge sys_clk);
      end else wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic write_byte(input logic [7:0] b, input int glo, input int ghi, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bus_bit(b[i], (i == glo) ? 1 : ((i == ghi) ? 2 : 0), s);
      bus_bit(1'b1, 0, s);
      ack = (s === 1'b0);
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] d);
      logic s;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         bus_bit(1'b1, 0, s);
         d = {d[6:0], s};
      end
      bus_bit(~ack, 0, s);
   endtask

   task automatic expect_write(input logic [7:0] d);
      exp_wr_q.push_back({model_ptr, d});
      model_mem[model_ptr] = d;
      model_ptr = model_ptr + 4'd1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (5) @(negedge sys_clk);
      n_run++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b expected 1", sda); end
      n_run++; if (regs_bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", regs_bus.busy); end
      n_run++; if (regs_bus.wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_wr_strobe: got %b expected 0", regs_bus.wr_strobe); end
      n_run++; if ({regs_bus.wr_addr, regs_bus.wr_data} !== 12'h000) begin n_fail++; $display("FAIL reset_wr_addr_data: got %h expected 000", {regs_bus.wr_addr, regs_bus.wr_data}); end
      n_run++; if (regs_bus.reg0_data !== 8'h00) begin n_fail++; $display("FAIL reset_reg0: got %h expected 00", regs_bus.reg0_data); end
      rst = 1'b0;
      repeat (10) @(negedge sys_clk);
   endtask

   task automatic test_write();
      logic a0, a1, a2;
      bus_start();
      write_byte(8'hA0, -1, -1, a0);
      n_run++; if (regs_bus.busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_active: got %b expected 1", regs_bus.busy); end
      write_byte(8'h00, -1, -1, a1);
      model_ptr = 4'd0;
      expect_write(8'h5A);
      write_byte(8'h5A, -1, -1, a2);
      bus_stop(); wait_q();
      n_run++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL write_acks: got %b expected 111", {a0, a1, a2}); end
      n_run++; if (regs_bus.reg0_data !== 8'h5A) begin n_fail++; $display("FAIL write_reg0: got %h expected 5a", regs_bus.reg0_data); end
      n_run++; if (regs_bus.busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop: got %b expected 0", regs_bus.busy); end
      n_run++; if (exp_wr_q.size() != 0) begin n_fail++; $display("FAIL write_missing_strobe: got %0d pending expected 0", exp_wr_q.size()); end
   endtask

   task automatic test_back_to_back();
      logic [4:0] acks;
      bus_start();
      write_byte(8'hA0, -1, -1, acks[4]);
      write_byte(8'h0E, -1, -1, acks[3]);
      model_ptr = 4'd14;
      expect_write(8'h11); write_byte(8'h11, -1, -1, acks[2]);
      expect_write(8'h22); write_byte(8'h22, -1, -1, acks[1]);
      expect_write(8'h33); write_byte(8'h33, -1, -1, acks[0]);
      bus_stop(); wait_q();
      n_run++; if (acks !== 5'b11111) begin n_fail++; $display("FAIL b2b_acks: got %b expected 11111", acks); end
      n_run++; if (regs_bus.reg0_data !== model_mem[0]) begin n_fail++; $display("FAIL b2b_wrap_reg0: got %h expected %h", regs_bus.reg0_data, model_mem[0]); end
      n_run++; if (exp_wr_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing_strobe: got %0d pending expected 0", exp_wr_q.size()); end
   endtask

   task automatic test_random_read();
      logic [2:0] acks;
      logic [7:0] d, e;
      bus_start();
      write_byte(8'hA0, -1, -1, acks[2]);
      write_byte(8'h0F, -1, -1, acks[1]);
      model_ptr = 4'd15;
      bus_start();
      write_byte(8'hA1, -1, -1, acks[0]);
      exp_rd_q.push_back(model_mem[model_ptr]);
      read_byte(1'b1, d);
      e = exp_rd_q.pop_front();
      n_run++; if (d !== e) begin n_fail++; $display("FAIL rd_reg15: got %h expected %h", d, e); end
      model_ptr = model_ptr + 4'd1;
      exp_rd_q.push_back(model_mem[model_ptr]);
      read_byte(1'b0, d);
      e = exp_rd_q.pop_front();
      n_run++; if (d !== e) begin n_fail++; $display("FAIL rd_wrap_reg0: got %h expected %h", d, e); end
      n_run++; if (sda !== 1'b1) begin n_fail++; $display("FAIL rd_release_after_nack: got %b expected 1", sda); end
      bus_stop(); wait_q();
      n_run++; if (acks !== 3'b111) begin n_fail++; $display("FAIL rd_acks: got %b expected 111", acks); end
   endtask

   task automatic test_ptr_persist();
      logic       a;
      logic [7:0] d, e;
      bus_start();
      write_byte(8'hA1, -1, -1, a);
      exp_rd_q.push_back(model_mem[model_ptr]);
      read_byte(1'b0, d);
      e = exp_rd_q.pop_front();
      bus_stop(); wait_q();
      n_run++; if (a !== 1'b1) begin n_fail++; $display("FAIL persist_ack: got %b expected 1", a); end
      n_run++; if (d !== e) begin n_fail++; $display("FAIL persist_data: got %h expected %h", d, e); end
   endtask

   task automatic test_mismatch();
      logic a0, a1;
      bus_start();
      write_byte(8'hA2, -1, -1, a0);
      n_run++; if (regs_bus.busy !== 1'b0) begin n_fail++; $display("FAIL mismatch_busy: got %b expected 0", regs_bus.busy); end
      write_byte(8'h77, -1, -1, a1);
      bus_stop(); wait_q();
      n_run++; if ({a0, a1} !== 2'b00) begin n_fail++; $display("FAIL mismatch_no_ack: got %b expected 00", {a0, a1}); end
      n_run++; if (regs_bus.busy !== 1'b0) begin n_fail++; $display("FAIL mismatch_busy_end: got %b expected 0", regs_bus.busy); end
   endtask

   task automatic test_partial();
      logic       a, s;
      logic [3:0] acks;
      logic [7:0] d, e;
      bus_start();
      write_byte(8'hA0, -1, -1, acks[3]);
      write_byte(8'h03, -1, -1, acks[2]);
      model_ptr = 4'd3;
      for (int i = 0; i < 5; i++) bus_bit(1'b1, 0, s);
      bus_stop(); wait_q();
      n_run++; if (regs_bus.busy !== 1'b0) begin n_fail++; $display("FAIL partial_busy: got %b expected 0", regs_bus.busy); end
      bus_start();
      write_byte(8'hA0, -1, -1, acks[1]);
      write_byte(8'h03, -1, -1, acks[0]);
      bus_start();
      write_byte(8'hA1, -1, -1, a);
      exp_rd_q.push_back(model_mem[model_ptr]);
      read_byte(1'b0, d);
      e = exp_rd_q.pop_front();
      bus_stop(); wait_q();
      n_run++; if ({acks, a} !== 5'b11111) begin n_fail++; $display("FAIL partial_acks: got %b expected 11111", {acks, a}); end
      n_run++; if (d !== e) begin n_fail++; $display("FAIL partial_reg_unchanged: got %h expected %h", d, e); end
   endtask

   task automatic test_glitch();
      logic [2:0] acks;
      bus_start();
      write_byte(8'hA0, -1, -1, acks[2]);
      write_byte(8'h04, -1, -1, acks[1]);
      model_ptr = 4'd4;
      expect_write(8'hC3);
      write_byte(8'hC3, 3, 5, acks[0]);
      bus_stop(); wait_q();
      n_run++; if (acks !== 3'b111) begin n_fail++; $display("FAIL glitch_acks: got %b expected 111", acks); end
      n_run++; if (exp_wr_q.size() != 0) begin n_fail++; $display("FAIL glitch_missing_strobe: got %0d pending expected 0", exp_wr_q.size()); end
   endtask

   task automatic test_reset_ack();
      logic       s;
      logic [2:0] acks;
      logic [7:0] addr;
      addr = 8'hA0;
      bus_start();
      for (int i = 7; i >= 0; i--) bus_bit(addr[i], 0, s);
      sda_m_low = 1'b0;
      @(negedge sys_clk);
      n_run++; if (sda !== 1'b0) begin n_fail++; $display("FAIL rstack_ack_driven: got %b expected 0", sda); end
      @(negedge sys_clk); #2;
      rst = 1'b1; #1;
      n_run++; if (sda !== 1'b1) begin n_fail++; $display("FAIL rstack_async_release: got %b expected 1", sda); end
      @(negedge sys_clk);
      n_run++; if ({regs_bus.busy, regs_bus.wr_strobe, regs_bus.wr_addr, regs_bus.wr_data, regs_bus.reg0_data} !== 22'h0)
         begin n_fail++; $display("FAIL rstack_outputs: got %h expected 0", {regs_bus.busy, regs_bus.wr_strobe, regs_bus.wr_addr, regs_bus.wr_data, regs_bus.reg0_data}); end
      for (int k = 0; k < 16; k++) model_mem[k] = 8'h00;
      model_ptr = 4'd0;
      rst = 1'b0;
      scl_m = 1'b1; wait_q();
      bus_start();
      write_byte(8'hA0, -1, -1, acks[2]);
      write_byte(8'h02, -1, -1, acks[1]);
      model_ptr = 4'd2;
      expect_write(8'h99);
      write_byte(8'h99, -1, -1, acks[0]);
      bus_stop(); wait_q();
      n_run++; if (acks !== 3'b111) begin n_fail++; $display("FAIL rstack_next_write_acks: got %b expected 111", acks); end
      n_run++; if (regs_bus.reg0_data !== model_mem[0]) begin n_fail++; $display("FAIL rstack_regs_cleared: got %h expected %h", regs_bus.reg0_data, model_mem[0]); end
      n_run++; if (exp_wr_q.size() != 0) begin n_fail++; $display("FAIL rstack_missing_strobe: got %0d pending expected 0", exp_wr_q.size()); end
   endtask

   initial begin
      for (int k = 0; k < 16; k++) model_mem[k] = 8'h00;
      model_ptr = 4'd0;
      test_reset();
      test_write();
      test_back_to_back();
      test_random_read();
      test_ptr_persist();
      test_mismatch();
      test_partial();
      test_glitch();
      test_reset_ack();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
